// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one simple-dual-port data RAM (write port A, read port B with a
//   1-cycle registered read) between the CPU and the debug/loader port.
//   At most one memory operation is granted per clock. The CPU has fixed
//   priority, but a starvation counter forces the debug port ahead after
//   STARVE_MAX consecutive CPU grants while debug is waiting.
//
// Ports
//   clk_i, rst_i            system clock, synchronous active-high reset
//   cpu_*_i / cpu_*_o       CPU request (req/we/addr/wdata), grant, read return
//   dbg_*_i / dbg_*_o       debug port, same shape as the CPU port
//   mem_cea_o/ada_o/din_o   RAM write port A
//   mem_ceb_o/adb_o         RAM read port B
//   mem_oce_o               RAM output clock enable, tied high
//   mem_reset_o             RAM reset, follows rst_i
//   mem_dout_i              RAM read data, valid the cycle after mem_ceb_o
//
// state          | meaning
// ARB_CPU        | normal fixed priority, CPU wins when it requests
// ARB_DBG_FORCED | debug has waited STARVE_MAX CPU grants; debug wins next

module data_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_cea_o,
  output logic [ADDR_W-1:0] mem_ada_o,
  output logic [DATA_W-1:0] mem_din_o,
  output logic              mem_ceb_o,
  output logic [ADDR_W-1:0] mem_adb_o,
  output logic              mem_oce_o,
  output logic              mem_reset_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {
    ARB_CPU        = 1'b0,
    ARB_DBG_FORCED = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  arb_state_e        state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  owner_e            rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] ada_q, ada_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [ADDR_W-1:0] adb_q, adb_d;

  logic              force_dbg;
  logic              cpu_gnt, dbg_gnt, any_gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              wr_en, rd_en;

  // ARB_DBG_FORCED is held exactly when the starvation count sits at its
  // limit, so the state alone tells us debug must win if it still asks.
  always_comb begin
    force_dbg = dbg_req_i && (state_q == ARB_DBG_FORCED);
    cpu_gnt   = !rst_i && !force_dbg && cpu_req_i;
    dbg_gnt   = !rst_i && (force_dbg || (!cpu_req_i && dbg_req_i));
    any_gnt   = cpu_gnt || dbg_gnt;

    win_we    = dbg_gnt ? dbg_we_i    : cpu_we_i;
    win_addr  = dbg_gnt ? dbg_addr_i  : cpu_addr_i;
    win_wdata = dbg_gnt ? dbg_wdata_i : cpu_wdata_i;

    wr_en     = any_gnt && win_we;
    rd_en     = any_gnt && !win_we;
  end

  // Address/data lines keep their last driven value on idle cycles.
  always_comb begin
    ada_d = wr_en ? win_addr  : ada_q;
    din_d = wr_en ? win_wdata : din_q;
    adb_d = rd_en ? win_addr  : adb_q;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (dbg_gnt || !dbg_req_i) begin
      starve_cnt_d = '0;
    end else if (cpu_gnt) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end

    state_d = (starve_cnt_d == STARVE_LIM) ? ARB_DBG_FORCED : ARB_CPU;

    rd_pend_d  = rd_en;
    rd_owner_d = rd_owner_q;
    if (rd_en) begin
      rd_owner_d = dbg_gnt ? OWN_DBG : OWN_CPU;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ARB_CPU;
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= OWN_CPU;
      ada_q        <= '0;
      din_q        <= '0;
      adb_q        <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      ada_q        <= ada_d;
      din_q        <= din_d;
      adb_q        <= adb_d;
    end
  end

  // rst_i gating drops the return of a read granted just before reset.
  assign cpu_rvalid_o = !rst_i && rd_pend_q && (rd_owner_q == OWN_CPU);
  assign dbg_rvalid_o = !rst_i && rd_pend_q && (rd_owner_q == OWN_DBG);
  assign cpu_rdata_o  = mem_dout_i;
  assign dbg_rdata_o  = mem_dout_i;

  assign cpu_gnt_o   = cpu_gnt;
  assign dbg_gnt_o   = dbg_gnt;
  assign mem_cea_o   = wr_en;
  assign mem_ada_o   = ada_d;
  assign mem_din_o   = din_d;
  assign mem_ceb_o   = rd_en;
  assign mem_adb_o   = adb_d;
  assign mem_oce_o   = 1'b1;
  assign mem_reset_o = rst_i;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: directed scenarios followed by randomized
// traffic compared against a request-level arbitration/memory model.

module tb_data_mem_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          mem_cea, mem_ceb, mem_oce, mem_reset;
  logic [AW-1:0] mem_ada, mem_adb;
  logic [DW-1:0] mem_din, mem_dout;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] ram [256];
  logic [DW-1:0] shadow [256];

  always #5 clk = ~clk;

  // RAM model: port A write, port B registered read.
  always @(posedge clk) begin
    if (mem_cea) ram[mem_ada] <= mem_din;
    if (mem_ceb) mem_dout <= ram[mem_adb];
  end

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .mem_cea_o(mem_cea), .mem_ada_o(mem_ada), .mem_din_o(mem_din),
    .mem_ceb_o(mem_ceb), .mem_adb_o(mem_adb), .mem_oce_o(mem_oce),
    .mem_reset_o(mem_reset), .mem_dout_i(mem_dout)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d;
  endtask

  // One-cycle CPU write with debug idle; granted immediately.
  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_cpu(1'b1, 1'b1, a, d);
    shadow[a] = d;
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_cpu(1'b1, 1'b0, 8'h00, 8'h00);
    set_dbg(1'b1, 1'b0, 8'h00, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_cea, mem_ceb} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_quiet cycle %0d: got gnt/rv/ce %b required 000000", c,
                 {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_cea, mem_ceb});
      end
      n_vec++;
      if ({mem_reset, mem_oce} !== 2'b11) begin
        n_err++;
        $display("FAIL reset_mem_pins: got reset/oce %b required 11", {mem_reset, mem_oce});
      end
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({cpu_gnt, dbg_gnt, mem_reset} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_first_grant: got cpu/dbg/mreset %b required 100", {cpu_gnt, dbg_gnt, mem_reset});
    end
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0);
    next_cycle();
    next_cycle();
  endtask

  task automatic test_write_read();
    set_cpu(1'b1, 1'b1, 8'h10, 8'h5A);
    shadow[8'h10] = 8'h5A;
    @(negedge clk);
    n_vec++;
    if ({cpu_gnt, mem_cea, mem_ceb, mem_ada, mem_din} !== {3'b110, 8'h10, 8'h5A}) begin
      n_err++;
      $display("FAIL wr_pulse: got gnt/cea/ceb/ada/din %b/%b/%b/%h/%h required 1/1/0/10/5a",
               cpu_gnt, mem_cea, mem_ceb, mem_ada, mem_din);
    end
    next_cycle();
    set_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    n_vec++;
    if ({cpu_gnt, mem_cea, mem_ceb, mem_adb, cpu_rvalid} !== {3'b101, 8'h10, 1'b0}) begin
      n_err++;
      $display("FAIL rd_issue: got gnt/cea/ceb/adb/rv %b/%b/%b/%h/%b required 1/0/1/10/0",
               cpu_gnt, mem_cea, mem_ceb, mem_adb, cpu_rvalid);
    end
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_vec++;
    if ({cpu_rvalid, dbg_rvalid, cpu_rdata} !== {2'b10, 8'h5A}) begin
      n_err++;
      $display("FAIL raw_return: got cpu_rv/dbg_rv/rdata %b/%b/%h required 1/0/5a", cpu_rvalid, dbg_rvalid, cpu_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_vec++;
    if ({cpu_rvalid, dbg_rvalid, mem_cea, mem_ceb} !== 4'b0) begin
      n_err++;
      $display("FAIL idle_after_read: got %b required 0000", {cpu_rvalid, dbg_rvalid, mem_cea, mem_ceb});
    end
    next_cycle();
  endtask

  task automatic test_pipelined();
    logic [DW-1:0] exp;
    for (int i = 1; i <= 3; i++) cpu_write(AW'(i), 8'hA0 + DW'(i));
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) set_cpu(1'b1, 1'b0, AW'(i + 1), 8'h00);
      else set_cpu(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      exp = 8'hA0 + DW'(i);
      n_vec++;
      if (i == 0) begin
        if (cpu_rvalid !== 1'b0) begin
          n_err++;
          $display("FAIL pipe_first: got cpu_rvalid %b required 0", cpu_rvalid);
        end
      end else if ({cpu_rvalid, dbg_rvalid, cpu_rdata} !== {2'b10, exp}) begin
        n_err++;
        $display("FAIL pipe_read %0d: got rv/dbg_rv/rdata %b/%b/%h required 1/0/%h", i, cpu_rvalid, dbg_rvalid, cpu_rdata, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_starvation();
    logic exp_dbg;
    set_dbg(1'b1, 1'b1, 8'h20, 8'h77);
    shadow[8'h20] = 8'h77;
    @(negedge clk);
    n_vec++;
    if ({dbg_gnt, cpu_gnt, mem_cea, mem_ada, mem_din} !== {3'b101, 8'h20, 8'h77}) begin
      n_err++;
      $display("FAIL dbg_write: got dgnt/cgnt/cea/ada/din %b/%b/%b/%h/%h required 1/0/1/20/77",
               dbg_gnt, cpu_gnt, mem_cea, mem_ada, mem_din);
    end
    next_cycle();
    set_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    set_dbg(1'b1, 1'b0, 8'h20, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_dbg = (c == 5) || (c == 12);
      n_vec++;
      if ({cpu_gnt, dbg_gnt} !== {!exp_dbg, exp_dbg}) begin
        n_err++;
        $display("FAIL starve_grant cycle %0d: got cpu/dbg %b%b required %b%b", c, cpu_gnt, dbg_gnt, !exp_dbg, exp_dbg);
      end
      n_vec++;
      if ({cpu_rvalid, dbg_rvalid} !== {(c >= 2 && c != 6), (c == 6)}) begin
        n_err++;
        $display("FAIL starve_rvalid cycle %0d: got cpu/dbg %b%b required %b%b", c, cpu_rvalid, dbg_rvalid,
                 (c >= 2 && c != 6), (c == 6));
      end
      if (c == 6) begin
        n_vec++;
        if (dbg_rdata !== 8'h77) begin
          n_err++;
          $display("FAIL starve_dbg_data: got %h required 77", dbg_rdata);
        end
      end
      next_cycle();
      if (c == 5) dbg_req = 1'b0;
      if (c == 7) dbg_req = 1'b1;
    end
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0);
    next_cycle();
    next_cycle();
  endtask

  task automatic test_interleaved();
    cpu_write(8'h30, 8'h11);
    cpu_write(8'h31, 8'h22);
    set_cpu(1'b1, 1'b0, 8'h30, 8'h00);
    @(negedge clk);
    n_vec++;
    if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
      n_err++;
      $display("FAIL inter_cpu_gnt: got %b%b required 10", cpu_gnt, dbg_gnt);
    end
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b1, 1'b0, 8'h31, 8'h00);
    @(negedge clk);
    n_vec++;
    if ({dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_rdata} !== {3'b110, 8'h11}) begin
      n_err++;
      $display("FAIL inter_n1: got dgnt/crv/drv/crdata %b/%b/%b/%h required 1/1/0/11", dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_rdata);
    end
    next_cycle();
    set_dbg(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_vec++;
    if ({cpu_rvalid, dbg_rvalid, dbg_rdata} !== {2'b01, 8'h22}) begin
      n_err++;
      $display("FAIL inter_n2: got crv/drv/drdata %b/%b/%h required 0/1/22", cpu_rvalid, dbg_rvalid, dbg_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    logic exp_dbg;
    set_dbg(1'b1, 1'b0, 8'h20, 8'h00);
    @(negedge clk);
    n_vec++;
    if ({dbg_gnt, mem_ceb} !== 2'b11) begin
      n_err++;
      $display("FAIL rmr_grant: got dgnt/ceb %b%b required 11", dbg_gnt, mem_ceb);
    end
    next_cycle();
    rst = 1'b1;
    set_dbg(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_vec++;
    if ({dbg_rvalid, cpu_rvalid, mem_ceb, mem_cea} !== 4'b0) begin
      n_err++;
      $display("FAIL rmr_no_rvalid: got drv/crv/ceb/cea %b required 0000", {dbg_rvalid, cpu_rvalid, mem_ceb, mem_cea});
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({dbg_rvalid, cpu_rvalid} !== 2'b0) begin
      n_err++;
      $display("FAIL rmr_after: got drv/crv %b required 00", {dbg_rvalid, cpu_rvalid});
    end
    next_cycle();
    // Build up starvation count to 3, reset, then expect a full 4-grant wait.
    set_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    set_dbg(1'b1, 1'b0, 8'h20, 8'h00);
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp_dbg = (c == 5);
      n_vec++;
      if ({cpu_gnt, dbg_gnt} !== {!exp_dbg, exp_dbg}) begin
        n_err++;
        $display("FAIL rmr_cnt_cleared cycle %0d: got cpu/dbg %b%b required %b%b", c, cpu_gnt, dbg_gnt, !exp_dbg, exp_dbg);
      end
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0);
    next_cycle();
    next_cycle();
  endtask

  task automatic test_random();
    int            waits;
    logic          pend, pend_dbg, exp_cpu, exp_dbg, cpu_done, dbg_done;
    logic [DW-1:0] pend_data;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 16; i++) cpu_write(AW'(i), DW'($urandom_range(0, 255)));
    next_cycle();
    waits = 0; pend = 1'b0; pend_dbg = 1'b0; pend_data = '0;
    cpu_done = 1'b1; dbg_done = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (cpu_done || !cpu_req)
        set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
      if (dbg_done || !dbg_req)
        set_dbg($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
      @(negedge clk);
      // Debug wins if CPU is idle or debug has already waited SMAX CPU grants.
      exp_dbg = dbg_req && (waits >= SMAX || !cpu_req);
      exp_cpu = cpu_req && !exp_dbg;
      n_vec++;
      if ({cpu_gnt, dbg_gnt} !== {exp_cpu, exp_dbg}) begin
        n_err++;
        $display("FAIL rnd_grant step %0d: got cpu/dbg %b%b required %b%b", n, cpu_gnt, dbg_gnt, exp_cpu, exp_dbg);
      end
      n_vec++;
      if ({cpu_rvalid, dbg_rvalid} !== {pend && !pend_dbg, pend && pend_dbg}) begin
        n_err++;
        $display("FAIL rnd_rvalid step %0d: got cpu/dbg %b%b required %b%b", n, cpu_rvalid, dbg_rvalid,
                 pend && !pend_dbg, pend && pend_dbg);
      end
      if (pend) begin
        n_vec++;
        if ((pend_dbg ? dbg_rdata : cpu_rdata) !== pend_data) begin
          n_err++;
          $display("FAIL rnd_rdata step %0d: got %h required %h", n, pend_dbg ? dbg_rdata : cpu_rdata, pend_data);
        end
      end
      w = exp_dbg ? dbg_we : cpu_we;
      a = exp_dbg ? dbg_addr : cpu_addr;
      d = exp_dbg ? dbg_wdata : cpu_wdata;
      n_vec++;
      if (!(exp_cpu || exp_dbg)) begin
        if ({mem_cea, mem_ceb} !== 2'b00) begin
          n_err++;
          $display("FAIL rnd_idle step %0d: got cea/ceb %b%b required 00", n, mem_cea, mem_ceb);
        end
      end else if (w) begin
        if ({mem_cea, mem_ceb, mem_ada, mem_din} !== {2'b10, a, d}) begin
          n_err++;
          $display("FAIL rnd_write step %0d: got cea/ceb/ada/din %b%b/%h/%h required 10/%h/%h", n, mem_cea, mem_ceb, mem_ada, mem_din, a, d);
        end
      end else begin
        if ({mem_cea, mem_ceb, mem_adb} !== {2'b01, a}) begin
          n_err++;
          $display("FAIL rnd_read step %0d: got cea/ceb/adb %b%b/%h required 01/%h", n, mem_cea, mem_ceb, mem_adb, a);
        end
      end
      pend = 1'b0;
      if (exp_cpu || exp_dbg) begin
        if (w) shadow[a] = d;
        else begin
          pend = 1'b1;
          pend_dbg = exp_dbg;
          pend_data = shadow[a];
        end
      end
      if (exp_dbg || !dbg_req) waits = 0;
      else if (exp_cpu) waits++;
      cpu_done = exp_cpu;
      dbg_done = exp_dbg;
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0);
    next_cycle();
    test_reset();
    test_write_read();
    test_pipelined();
    test_starvation();
    test_interleaved();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the 256x8 simple-dual-port data RAM (write port A, read port B, 1-cycle registered read) between two requesters: the CPU (primary) and the debug/loader port (UART monitor).
- Grants at most one memory operation per clock.
- CPU has fixed priority; a starvation counter guarantees the debug port forward progress.
- Returns read data to the owner of each read with a valid strobe.

Parameters:
- ADDR_W, 8, address width; matches RAM depth 2^ADDR_W.
- DATA_W, 8, data width.
- STARVE_MAX, 4, consecutive CPU grants while dbg_req is pending before the debug port is forced ahead; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  CPU request; held with its fields until cpu_gnt.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  request accepted this cycle (combinational).
- cpu_rvalid  out  1  cpu_rdata valid this cycle.
- cpu_rdata  out  DATA_W  CPU read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* ports, for the debug port.
- mem_cea  out  1  RAM write enable (port A CE).
- mem_ada  out  ADDR_W  RAM write address.
- mem_din  out  DATA_W  RAM write data.
- mem_ceb  out  1  RAM read enable (port B CE).
- mem_adb  out  ADDR_W  RAM read address.
- mem_oce  out  1  RAM output clock enable; tied to 1.
- mem_reset  out  1  RAM reset; equals rst.
- mem_dout  in  DATA_W  RAM read data, valid the cycle after mem_ceb.

Behaviour:
- Grant selection, combinational each cycle:
  - force = dbg_req && (starve_cnt == STARVE_MAX).
  - If force: dbg_gnt=1.
  - Else if cpu_req: cpu_gnt=1.
  - Else if dbg_req: dbg_gnt=1.
  - cpu_gnt and dbg_gnt are never both 1.
  - Neither grant is asserted while rst=1.
- Granted write: mem_cea=1 with mem_ada/mem_din from the winner, same cycle. Write is complete at the next edge; no response strobe.
- Granted read:
  - mem_ceb=1 with mem_adb from the winner, same cycle.
  - Registered rd_pend<=1 and rd_owner<=winner.
  - Next cycle: owner's *_rvalid=1, *_rdata=mem_dout. Latency is exactly 1 cycle.
- Back-to-back reads (one per cycle, either owner) are fully pipelined; every read yields exactly one rvalid.
- Idle cycle: mem_cea=0, mem_ceb=0; address/data outputs hold their last driven values (don't-care).
- Both rdata outputs carry mem_dout. Only the owner's rvalid is asserted; the non-owner rvalid is 0.
- Read-after-write, same address, consecutive grants (write at N, read at N+1): rvalid at N+2 returns the new data. No bypass logic is needed because one grant is issued per cycle.
- starve_cnt (4-bit register), exactly one branch per cycle, in this priority:
  - Cleared to 0 when dbg_gnt or !dbg_req.
  - Else incremented (saturating at STARVE_MAX) when cpu_gnt && dbg_req.
  - Else held.
- Arbitration state machine ARB_CPU / ARB_DBG_FORCED:
  - ARB_DBG_FORCED is entered when starve_cnt reaches STARVE_MAX while dbg_req=1.
  - It lasts exactly the one cycle in which dbg is granted, then returns to ARB_CPU.
  - If dbg_req drops before service, return to ARB_CPU and clear the counter.
- Reset (synchronous) clears: starve_cnt=0, rd_pend=0, rd_owner=CPU, state=ARB_CPU.
  - All grants, rvalids and mem_cea/mem_ceb are 0 during reset.
  - A read granted in the cycle before reset asserts produces no rvalid.
  - First grant is possible in the first cycle with rst=0.
- Requesters must hold req and its fields stable until granted. Behaviour with changing fields before grant is undefined except that no spurious memory op occurs without a grant.

Test Plan:
- Reset: hold rst 3 cycles with cpu_req=dbg_req=1 -> all grants, rvalids, mem_cea, mem_ceb = 0; first cycle after release cpu_gnt=1.
- CPU write 0x5A to 0x10, then CPU read 0x10 next cycle -> mem_cea pulse at addr 0x10; cpu_rvalid=1 with cpu_rdata=0x5A exactly 1 cycle after the read grant; dbg_rvalid stays 0.
- Pipelined reads: CPU reads 0x01, 0x02, 0x03 back-to-back (preloaded 0xA1,0xA2,0xA3) -> three consecutive cpu_rvalid cycles with 0xA1, 0xA2, 0xA3.
- Starvation: cpu_req held high continuously, dbg read of 0x20 (=0x77) raised -> 4 CPU grants, then dbg_gnt on the 5th cycle, dbg_rvalid with 0x77 next cycle, then CPU resumes; starve_cnt back to 0.
- Interleaved owners: CPU read 0x30 (=0x11) at N, dbg read 0x31 (=0x22) at N+1 -> cpu_rvalid/0x11 at N+1, dbg_rvalid/0x22 at N+2; never both rvalids in one cycle.
- Reset mid-read: dbg read granted at N, rst=1 at N+1 -> dbg_rvalid=0 at N+1; counter and state cleared.
